mimo_backsub_detector: RTL and testbench

Back-substitution symbol detector that consumes the output of the 4x4 MIMO sorted QR decomposition pipeline: upper-triangular real-valued 8x8 R, rotated receive vector Q^T·y, and the 8-entry column order. It solves R·x = y row by row from row 7 down to row 0, slicing each real dimension to a PAM-4 level {-3,-1,+1,+3}, which is 16-QAM per complex stream. It then un-permutes the decisions to the original antenna order. The block is iterative, one row per cycle, and uses a valid/ready handshake on both sides.

---
 rtl/mimo_backsub_detector.sv | 181 ++++++++++++++++++
 tb/tb_mimo_backsub_detector.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mimo_backsub_detector.sv
// mimo_backsub_detector
//
// Back-substitution symbol detector for the 4x4 MIMO sorted-QR pipeline.
// It solves R*x = y for an upper-triangular real-valued 8x8 R, one row per
// cycle from row 7 down to row 0. Each dimension is sliced to a PAM-4 level
// {-3,-1,+1,+3}. The sorted-order decisions are then scattered back to the
// original antenna columns.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   in_valid   problem inputs valid
//   in_ready   block is idle and can accept a problem
//   Rmat_i     R(r,c) at [(8r+c)*WL +: WL]; only c>=r is used
//   Yarr_i     y(i) at [i*WL +: WL]
//   colorder_i original column index of sorted position k at [3k +: 3]
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   x_o        decision for original column m at [3m +: 3], 3-bit signed
//   diag_err   some R(i,i) <= 0 was seen in this problem
//   perm_err   colorder_i was not a permutation of 0..7
module mimo_backsub_detector #(
    parameter int WL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [64*WL-1:0] Rmat_i,
    input  logic [8*WL-1:0]  Yarr_i,
    input  logic [23:0]      colorder_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      x_o,
    output logic             diag_err,
    output logic             perm_err
);

    // Residual width: y plus seven terms of magnitude up to 3*|R| cannot
    // exceed 22 * 2^(WL-1), so WL+5 bits never overflow.
    localparam int EW = WL + 5;

    localparam logic [2:0] LVL_P3 = 3'b011;
    localparam logic [2:0] LVL_P1 = 3'b001;
    localparam logic [2:0] LVL_M1 = 3'b111;
    localparam logic [2:0] LVL_M3 = 3'b101;

    typedef enum logic [1:0] {IDLE, SOLVE, REORDER, OUT} state_t;

    state_t            state, state_nx;
    logic [64*WL-1:0]  r_q;
    logic [8*WL-1:0]   y_q;
    logic [23:0]       col_q;
    logic [2:0]        xs [8];
    logic [2:0]        row;
    logic              diag_err_r;

    logic signed [EW-1:0] e;
    logic signed [EW-1:0] two_d;
    logic signed [WL-1:0] d;
    logic                 diag_bad;
    logic [2:0]           xs_new;
    logic [23:0]          x_nx;
    logic                 perm_nx;

    // R(i,j)*x for x in {+-1,+-3} built from a shift and an add.
    function automatic logic signed [EW-1:0] term(input logic [WL-1:0] r,
                                                 input logic [2:0]    x);
        logic signed [EW-1:0] rr;
        logic signed [EW-1:0] mag;
        rr  = {{5{r[WL-1]}}, r};
        mag = (x == LVL_P3 || x == LVL_M3) ? (rr <<< 1) + rr : rr;
        if (x == 3'b000)
            return '0;
        return x[2] ? -mag : mag;
    endfunction

    assign in_ready = rst & (state == IDLE);

    // Residual and slicer for the current row.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        e = {{5{y_q[int'(row)*WL + WL-1]}}, y_q[int'(row)*WL +: WL]};
        for (int j = 0; j < 8; j++) begin
            if (j > int'(row))
                e = e - term(r_q[(8*int'(row)+j)*WL +: WL], xs[j]);
        end
        d        = r_q[(9*int'(row))*WL +: WL];
        two_d    = {{5{d[WL-1]}}, d} <<< 1;
        diag_bad = d[WL-1] || (d == '0);
        if (diag_bad)
            xs_new = LVL_P1;
        else if (e >= two_d)
            xs_new = LVL_P3;
        else if (!e[EW-1])
            xs_new = LVL_P1;
        else if (e >= -two_d)
            xs_new = LVL_M1;
        else
            xs_new = LVL_M3;
    end

    // Scatter sorted decisions back to original columns; a later k
    // overwrites an earlier one when colorder has duplicates.
    always_comb begin
        x_nx    = '0;
        perm_nx = 1'b0;
        for (int k = 0; k < 8; k++)
            x_nx[3*int'(col_q[3*k +: 3]) +: 3] = xs[k];
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                if (col_q[3*a +: 3] == col_q[3*b +: 3])
                    perm_nx = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = SOLVE;
            SOLVE:   if (row == '0)  state_nx = REORDER;
            REORDER:                 state_nx = OUT;
            OUT:     if (out_ready)  state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            r_q        <= '0;
            y_q        <= '0;
            col_q      <= '0;
            row        <= '0;
            diag_err_r <= 1'b0;
            out_valid  <= 1'b0;
            x_o        <= '0;
            diag_err   <= 1'b0;
            perm_err   <= 1'b0;
            // NOTE: the decision array is small register state, not RAM, and
            // must read as zero after reset, so it is cleared element-wise.
            for (int k = 0; k < 8; k++)
                xs[k] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_q   <= Rmat_i;
                        y_q   <= Yarr_i;
                        col_q <= colorder_i;
                        row   <= 3'd7;
                    end
                end
                SOLVE: begin
                    xs[row] <= xs_new;
                    if (diag_bad)
                        diag_err_r <= 1'b1;
                    if (row != '0)
                        row <= row - 3'd1;
                end
                REORDER: begin
                    x_o       <= x_nx;
                    perm_err  <= perm_nx;
                    diag_err  <= diag_err_r;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        diag_err_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mimo_backsub_detector.sv
// Self-checking bench for mimo_backsub_detector: directed cases plus
// randomized problems checked by a scoreboard against a reference model.
module tb_mimo_backsub_detector;

    localparam int WL = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [64*WL-1:0] rmat = '0;
    logic [8*WL-1:0]  yarr = '0;
    logic [23:0]      colorder = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [23:0]      x_o;
    logic             diag_err;
    logic             perm_err;

    typedef struct {
        logic [23:0] x;
        logic        diag;
        logic        perm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   cap_cyc  = 0;
    bit   rand_bp  = 1'b0;

    int pr [8][8];
    int py [8];
    int pc [8];

    mimo_backsub_detector #(.WL(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Rmat_i     (rmat),
        .Yarr_i     (yarr),
        .colorder_i (colorder),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x_o        (x_o),
        .diag_err   (diag_err),
        .perm_err   (perm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [23:0] pack_x(input int v [8]);
        logic [23:0] r;
        logic [31:0] t;
        r = '0;
        for (int m = 0; m < 8; m++) begin
            t = v[m];
            r[3*m +: 3] = t[2:0];
        end
        return r;
    endfunction

    // Reference: plain integer back-substitution, then scatter by colorder.
    function automatic exp_t model();
        exp_t        r;
        int          xs [8];
        int          e, d;
        logic [23:0] xv;
        logic [31:0] t;
        r.diag = 1'b0;
        r.perm = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            e = py[i];
            for (int j = i + 1; j < 8; j++)
                e -= pr[i][j] * xs[j];
            d = pr[i][i];
            if (d <= 0) begin
                xs[i]  = 1;
                r.diag = 1'b1;
            end else if (e >= 2*d)  xs[i] = 3;
            else if (e >= 0)        xs[i] = 1;
            else if (e >= -2*d)     xs[i] = -1;
            else                    xs[i] = -3;
        end
        xv = '0;
        for (int k = 0; k < 8; k++) begin
            t = xs[k];
            xv[3*pc[k] +: 3] = t[2:0];
        end
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                if (pc[a] == pc[b]) r.perm = 1'b1;
        r.x = xv;
        return r;
    endfunction

    task automatic clear_prob();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) pr[r][c] = (r == c) ? 256 : 0;
            py[r] = 0;
            pc[r] = r;
        end
    endtask

    task automatic gen_random();
        int j, tmp, a, b;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (c > r)      pr[r][c] = int'($urandom_range(0, 600)) - 300;
                else if (c < r) pr[r][c] = int'($urandom_range(0, 65535)) - 32768;
                else if ($urandom_range(0, 19) == 0) pr[r][c] = -int'($urandom_range(0, 50));
                else            pr[r][c] = int'($urandom_range(64, 1024));
            end
            py[r] = int'($urandom_range(0, 8000)) - 4000;
            pc[r] = r;
        end
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = pc[i]; pc[i] = pc[j]; pc[j] = tmp;
        end
        if ($urandom_range(0, 9) == 0) begin
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            pc[a] = pc[b];
        end
    endtask

    task automatic load_inputs();
        logic [31:0] t;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                t = pr[r][c];
                rmat[(8*r+c)*WL +: WL] = t[WL-1:0];
            end
            t = py[r];
            yarr[r*WL +: WL] = t[WL-1:0];
            t = pc[r];
            colorder[3*r +: 3] = t[2:0];
        end
    endtask

    // Called one step after a rising edge; returns one step after capture.
    task automatic send(input exp_t ex);
        int guard = 0;
        load_inputs();
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_wait", {31'd0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(ex);
        #1;
        cap_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0)
            check("drain", exp_q.size(), 0);
    endtask

    // Monitor: compare each accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t ex;
                ex = exp_q.pop_front();
                check("x_o",      {8'd0, x_o},          {8'd0, ex.x});
                check("diag_err", {31'd0, diag_err},    {31'd0, ex.diag});
                check("perm_err", {31'd0, perm_err},    {31'd0, ex.perm});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ex;
        int   xv [8];
        int   lat, cons_cyc, guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_x_o",       {8'd0, x_o},        32'd0);
        check("rst_diag",      {31'd0, diag_err},  32'd0);
        check("rst_perm",      {31'd0, perm_err},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        rst = 1'b1;
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Identity problem with latency measurement
        clear_prob();
        py = '{768, 256, -256, -768, 600, 100, -100, -600};
        xv = '{3, 1, -1, -3, 3, 1, -1, -3};
        ex.x = pack_x(xv); ex.diag = 1'b0; ex.perm = 1'b0;
        send(ex);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 40);
        lat = cyc - cap_cyc;
        check("latency", lat, 9);
        @(posedge clk); #1;
        wait_drain();

        // Slicer boundaries
        clear_prob();
        py = '{512, 0, -512, 511, -1, -513, 513, -512};
        xv = '{3, 1, -1, 1, -1, -3, 3, -1};
        ex.x = pack_x(xv);
        send(ex);

        // Triangular: xs7=3, e6=-384 -> xs6=-1, remaining rows +1
        clear_prob();
        pr[6][7] = 128;
        py[7] = 768;
        xv = '{1, 1, 1, 1, 1, 1, -1, 3};
        ex.x = pack_x(xv);
        send(ex);

        // Reversed column order
        clear_prob();
        py = '{768, 256, -256, -768, 600, 100, -100, -600};
        pc = '{7, 6, 5, 4, 3, 2, 1, 0};
        send(model());

        // Duplicated column index
        pc = '{0, 1, 2, 3, 4, 5, 6, 0};
        send(model());

        // Non-positive diagonal, then a clean problem clears the flag
        clear_prob();
        py = '{300, -300, 700, 100, -700, 0, 200, -200};
        pr[3][3] = -5;
        send(model());
        pr[3][3] = 256;
        send(model());
        wait_drain();

        // Back-pressure: stall 20 cycles while upstream waves junk inputs
        out_ready = 1'b0;
        gen_random();
        ex = model();
        send(ex);
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            rmat = {32{$urandom()}};
            yarr = {4{$urandom()}};
            check("bp_x_o",      {8'd0, x_o},         {8'd0, ex.x});
            check("bp_valid",    {31'd0, out_valid},  32'd1);
            check("bp_in_ready", {31'd0, in_ready},   32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cons_cyc = cyc;
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        gen_random();
        send(model());
        check("bp_next_capture", cap_cyc - cons_cyc, 1);
        wait_drain();

        // Reset in the middle of SOLVE
        gen_random();
        send(model());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
        check("mid_rst_x_o",      {8'd0, x_o},        32'd0);
        check("mid_rst_diag",     {31'd0, diag_err},  32'd0);
        check("mid_rst_perm",     {31'd0, perm_err},  32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready},  32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_release", {31'd0, in_ready}, 32'd1);
        gen_random();
        send(model());
        wait_drain();

        // Randomized problems with random back-pressure
        rand_bp = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            gen_random();
            send(model());
        end
        wait_drain();
        rand_bp = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
